// File: rtl/if_fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// Entry layout, FSM encoding and PC arithmetic helpers.
package if_fetch_queue_pkg;

  localparam int          FQ_DEPTH    = 4;
  localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FQ_FETCH = 1'b0,
    FQ_FULL  = 1'b1
  } fq_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  // Next sequential fetch address; wraps 32'hFFFF_FFFC -> 0.
  function automatic logic [31:0] fq_next_pc(input logic [31:0] pc);
    return {pc[31:2] + 30'd1, 2'b00};
  endfunction

  function automatic logic [31:0] fq_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_queue_ram.sv
// DEPTH x {pc, inst} storage: one synchronous write port, one asynchronous read port.
// No reset on data; validity is tracked by the queue pointers and count.
module if_fetch_queue_ram
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fq_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output fq_entry_t     rdata
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch front end: sequential IAD generation, wait-state absorbing ring queue, valid/ready head toward IF/ID.
// Head appears 1 cycle after ACKI_n; IF_FQ_BYPASS_EN adds a same-cycle path when the queue is empty.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = FQ_DEPTH,
  parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  input  logic                   ACKI_n,
  input  logic [31:0]            IDT,
  output logic [31:0]            IAD,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_pc4,
  output logic [31:0]            out_inst,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fq_state_t     state;
  fq_state_t     state_nxt;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  fq_entry_t     head;
  fq_entry_t     hold;
  fq_entry_t     disp;
  fq_entry_t     wr_entry;

  logic not_empty;
  logic at_depth;
  logic bypass_hit;
  logic bypass_take;
  logic pop;
  logic qpop;
  logic push;
  logic advance;
  logic unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  assign not_empty = (count != '0);
  assign at_depth  = (count == DEPTH_C);

`ifdef IF_FQ_BYPASS_EN
  // Empty queue: forward the bus response straight to IF/ID this cycle.
  assign bypass_hit = !not_empty && (state == FQ_FETCH) && !ACKI_n && !redirect;
`else
  assign bypass_hit = 1'b0;
`endif

  assign bypass_take = bypass_hit & out_ready;

  assign out_valid = !redirect & (not_empty | bypass_hit);
  assign pop       = out_valid & out_ready;
  assign qpop      = pop & not_empty;

  // A bypassed-and-consumed response is never written; it still advances IAD.
  assign push    = (state == FQ_FETCH) & !ACKI_n & !redirect & !bypass_take
                 & (!at_depth | pop);
  assign advance = push | bypass_take;

  assign wr_entry = '{pc: IAD, inst: IDT};

  if_fetch_queue_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_comb begin
    disp = hold;
    if (not_empty) begin
      disp = head;
    end else if (bypass_hit) begin
      disp = '{pc: IAD, inst: IDT};
    end
  end

  assign out_pc   = disp.pc;
  assign out_inst = disp.inst;
  assign out_pc4  = disp.pc + 32'd4;

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = FQ_FETCH;
    end else begin
      unique case (state)
        FQ_FETCH: if (at_depth && !pop) state_nxt = FQ_FULL;
        FQ_FULL:  if (pop)              state_nxt = FQ_FETCH;
        default:                        state_nxt = FQ_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FQ_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      IAD    <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      IAD    <= fq_align(redirect_pc);
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (advance) IAD <= fq_next_pc(IAD);
      if (push)    wr_ptr <= wr_ptr + AW'(1);
      if (qpop)    rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, qpop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Last presented entry, shown while the queue is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
    end else begin
      hold <= disp;
    end
  end

endmodule
